// File: rtl/trig_func_seq_if.sv
// trig_func_seq_if: configuration, condition and status bundle for trig_func_seq.
//   master : drives cfg_we/cfg_lut/arm/disarm/din/match_len/holdoff, observes status
//   slave  : the trigger block itself; drives y/trig/armed/state/fire_cnt
interface trig_func_seq_if #(
  parameter int N_IN   = 4,
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 8
);
  logic                   cfg_we;
  logic [(1<<N_IN)-1:0]   cfg_lut;
  logic                   arm;
  logic                   disarm;
  logic [N_IN-1:0]        din;
  logic [CNT_W-1:0]       match_len;
  logic [HOLD_W-1:0]      holdoff;
  logic                   y;
  logic                   trig;
  logic                   armed;
  logic [1:0]             state;
  logic [CNT_W-1:0]       fire_cnt;

  modport master (
    output cfg_we, cfg_lut, arm, disarm, din, match_len, holdoff,
    input  y, trig, armed, state, fire_cnt
  );

  modport slave (
    input  cfg_we, cfg_lut, arm, disarm, din, match_len, holdoff,
    output y, trig, armed, state, fire_cnt
  );
endinterface

// File: rtl/trig_func_seq.sv
// trig_func_seq: programmable-LUT trigger with arm / match-run / hold-off sequencing.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : trig_func_seq_if.slave
//            in : cfg_we, cfg_lut (bit i = result for din==i), arm, disarm, din,
//                 match_len (0 behaves as 1), holdoff
//            out: y (registered LUT result), trig (1-cycle pulse), armed,
//                 state (0 IDLE, 1 ARMED, 2 HOLD), fire_cnt (saturating)
// Build option: TRIG_EDGE_EN -- fire on a rising edge of the LUT result instead of
//   on a run of match_len consecutive matches.
module trig_func_seq #(
  parameter int N_IN   = 4,
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  trig_func_seq_if.slave bus
);
  localparam int LUT_W = 1 << N_IN;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LUT_W-1:0]   lut_q;
  logic               y_q;
  logic               trig_q, trig_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   fire_q, fire_d;
  logic               match;
  logic               fire_cond;

  assign match = lut_q[bus.din];

`ifdef TRIG_EDGE_EN
  logic prev_q;
  assign fire_cond = match && !prev_q;
`else
  // One extra bit so a saturated run still compares correctly against match_len.
  logic [CNT_W:0] run_inc, need;
  assign run_inc   = {1'b0, run_q} + (CNT_W+1)'(1);
  assign need      = (bus.match_len == '0) ? (CNT_W+1)'(1) : {1'b0, bus.match_len};
  assign fire_cond = match && (run_inc >= need);
`endif

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hold_d  = hold_q;
    trig_d  = 1'b0;
    fire_d  = fire_q;
    if (bus.disarm) begin
      state_d = S_IDLE;
      run_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          run_d = '0;
          if (bus.arm) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (fire_cond) begin
            trig_d  = 1'b1;
            run_d   = '0;
            hold_d  = bus.holdoff;
            state_d = S_HOLD;
            if (fire_q != '1) fire_d = fire_q + CNT_W'(1);
          end else if (match) begin
            if (run_q != '1) run_d = run_q + CNT_W'(1);
          end else begin
            run_d = '0;
          end
        end
        S_HOLD: begin
          run_d = '0;
          if (hold_q == '0) state_d = S_ARMED;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        default: begin
          // Unused encoding recovers to IDLE.
          state_d = S_IDLE;
          run_d   = '0;
        end
      endcase
    end
    // A new table invalidates any partial run built on the old one.
    if (bus.cfg_we) run_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lut_q   <= '0;
      y_q     <= 1'b0;
      trig_q  <= 1'b0;
      run_q   <= '0;
      hold_q  <= '0;
      fire_q  <= '0;
    end else begin
      state_q <= state_d;
      if (bus.cfg_we) lut_q <= bus.cfg_lut;
      y_q     <= match;
      trig_q  <= trig_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      fire_q  <= fire_d;
    end
  end

`ifdef TRIG_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= match;
  end
`endif

  assign bus.y        = y_q;
  assign bus.trig     = trig_q;
  assign bus.armed    = (state_q == S_ARMED) || (state_q == S_HOLD);
  assign bus.state    = state_q;
  assign bus.fire_cnt = fire_q;
endmodule

// File: tb/tb_trig_func_seq.sv
module tb_trig_func_seq;
  localparam int N_IN = 4, CNT_W = 8, HOLD_W = 8;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trig_func_seq_if #(.N_IN(N_IN), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) bus ();
  trig_func_seq #(.N_IN(N_IN), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: cycle-level behaviour written from the rules with plain ints.
  logic [15:0] m_lut;
  int m_state, m_run, m_hold, m_fire;
  bit m_y, m_trig, m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lut = '0; m_state = 0; m_run = 0; m_hold = 0; m_fire = 0;
    m_y = 0; m_trig = 0; m_prev = 0;
  endtask

  task automatic model_update();
    bit mt, fire;
    int need, ns, nrun, nhold, nfire;
    bit ntrig;
    mt = m_lut[bus.din];
    need = (bus.match_len == 0) ? 1 : int'(bus.match_len);
`ifdef TRIG_EDGE_EN
    fire = (m_state == 1) && mt && !m_prev;
`else
    fire = (m_state == 1) && mt && (m_run + 1 >= need);
`endif
    ns = m_state; nrun = m_run; nhold = m_hold; nfire = m_fire; ntrig = 0;
    if (bus.disarm) begin
      ns = 0; nrun = 0;
    end else if (m_state == 0) begin
      nrun = 0;
      if (bus.arm) ns = 1;
    end else if (m_state == 1) begin
      if (fire) begin
        ntrig = 1; nrun = 0; nhold = int'(bus.holdoff); ns = 2;
        nfire = (m_fire < CMAX) ? m_fire + 1 : CMAX;
      end else if (mt) nrun = (m_run < CMAX) ? m_run + 1 : CMAX;
      else nrun = 0;
    end else begin
      nrun = 0;
      if (m_hold == 0) ns = 1;
      else nhold = m_hold - 1;
    end
    if (bus.cfg_we) begin
      nrun = 0;
      m_lut = bus.cfg_lut;
    end
    m_state = ns; m_run = nrun; m_hold = nhold; m_fire = nfire; m_trig = ntrig;
    m_y = mt; m_prev = mt;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_y"},     32'(bus.y),        32'(m_y));
    chk({pfx, "_trig"},  32'(bus.trig),     32'(m_trig));
    chk({pfx, "_armed"}, 32'(bus.armed),    32'((m_state == 1) || (m_state == 2)));
    chk({pfx, "_state"}, 32'(bus.state),    32'(m_state));
    chk({pfx, "_fcnt"},  32'(bus.fire_cnt), 32'(m_fire));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_outputs("cyc");
  endtask

  task automatic clear_inputs();
    bus.cfg_we = 0; bus.cfg_lut = '0; bus.arm = 0; bus.disarm = 0;
    bus.din = '0; bus.match_len = '0; bus.holdoff = '0;
  endtask

  // Asserts reset mid-cycle and checks outputs clear immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    chk({tag, "_trig"},  32'(bus.trig),     32'd0);
    chk({tag, "_armed"}, 32'(bus.armed),    32'd0);
    chk({tag, "_state"}, 32'(bus.state),    32'd0);
    chk({tag, "_fcnt"},  32'(bus.fire_cnt), 32'd0);
    chk({tag, "_y"},     32'(bus.y),        32'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic load_lut(input logic [15:0] lut);
    bus.cfg_we = 1; bus.cfg_lut = lut;
    tick();
    bus.cfg_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] seq3 [6];
    logic       exp3 [6];
    model_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1;
    tick();

    // Reset while in HOLD with fire_cnt=5.
    load_lut(16'h8000);
    bus.match_len = 1; bus.holdoff = 7; bus.arm = 1;
    tick();
    bus.arm = 0;
    for (int k = 0; k < 5; k++) begin
      bus.din = 4'hF;
      tick();
      if (k < 4) begin
        bus.din = 4'h0;
        repeat (8) tick();
      end
    end
    tick();
    chk("t1_pre_state", 32'(bus.state), 32'd2);
    chk("t1_pre_fcnt", 32'(bus.fire_cnt), 32'd5);
    do_reset("t1");

`ifndef TRIG_EDGE_EN
    // Run of 3 matches fires once.
    load_lut(16'h8000);
    bus.match_len = 3; bus.holdoff = 0; bus.arm = 1;
    tick();
    bus.arm = 0; bus.din = 4'hF;
    tick(); chk("t2_s1_trig", 32'(bus.trig), 32'd0);
    tick(); chk("t2_s2_trig", 32'(bus.trig), 32'd0);
    tick();
    chk("t2_s3_trig", 32'(bus.trig), 32'd1);
    chk("t2_fcnt", 32'(bus.fire_cnt), 32'd1);
    chk("t2_state", 32'(bus.state), 32'd2);
    bus.din = 4'h0;
    tick(); chk("t2_rearm", 32'(bus.state), 32'd1);

    // Broken run restarts the count.
    seq3 = '{4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF};
    exp3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bus.din = seq3[i];
      tick();
      chk($sformatf("t3_trig%0d", i), 32'(bus.trig), 32'(exp3[i]));
    end
    bus.din = 4'h0;
    tick();

    // match_len=1, holdoff=4: period of 6.
    do_reset("t4rst");
    load_lut(16'h8000);
    bus.match_len = 1; bus.holdoff = 4; bus.arm = 1;
    tick();
    bus.arm = 0; bus.din = 4'hF;
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk($sformatf("t4_trig%0d", i), 32'(bus.trig), 32'(i % 6 == 1));
      if (i % 6 == 1) chk($sformatf("t4_fcnt%0d", i), 32'(bus.fire_cnt), 32'(i / 6 + 1));
    end
    bus.din = 4'h0; bus.disarm = 1;
    tick();
    bus.disarm = 0;
`endif

    // disarm on the completing match; arm+disarm in IDLE.
    do_reset("t5rst");
    load_lut(16'h8000);
    bus.match_len = 1; bus.holdoff = 0; bus.arm = 1;
    tick();
    bus.arm = 0;
    tick();
    bus.din = 4'hF; bus.disarm = 1;
    tick();
    chk("t5_trig", 32'(bus.trig), 32'd0);
    chk("t5_state", 32'(bus.state), 32'd0);
    bus.arm = 1; bus.disarm = 1; bus.din = 4'h0;
    tick();
    chk("t5_armdis", 32'(bus.state), 32'd0);
    bus.arm = 0; bus.disarm = 0;

    // Held match for 10 cycles.
    bus.arm = 1;
    tick();
    bus.arm = 0; bus.din = 4'hF; n = 0;
    repeat (10) begin
      tick();
      n += int'(bus.trig);
    end
`ifdef TRIG_EDGE_EN
    chk("t6_ntrig", 32'(n), 32'd1);
`else
    chk("t6_ntrig", 32'(n), 32'd5);
`endif
    bus.din = 4'h0; bus.disarm = 1;
    tick();
    bus.disarm = 0;

    // match_len=0 behaves as 1.
    bus.match_len = 0; bus.arm = 1;
    tick();
    bus.arm = 0; bus.din = 4'hF;
    tick();
    chk("ml0_trig", 32'(bus.trig), 32'd1);
    bus.din = 4'h0; bus.disarm = 1;
    tick();
    bus.disarm = 0;

    // Randomised traffic against the model.
    load_lut(16'hA5C3);
    for (int i = 0; i < 400; i++) begin
      bus.din    = 4'($urandom);
      bus.arm    = ($urandom_range(3) == 0);
      bus.disarm = ($urandom_range(24) == 0);
      bus.cfg_we = (m_state == 0) && ($urandom_range(4) == 0);
      bus.cfg_lut = 16'($urandom | $urandom);
      if ($urandom_range(15) == 0) bus.match_len = 8'($urandom_range(3));
      if ($urandom_range(7) == 0)  bus.holdoff   = 8'($urandom_range(3));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
